// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int MASK_W_DEF = DATA_W_DEF / 8;
  // Wide enough for the largest allowed MAX_WAIT (15)
  localparam int WAIT_W     = 4;

  function automatic int mask_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between IFU and LSU for one IDLE cycle.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int LSU_PRIO = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              if_valid,
  input  logic              ls_valid,
  input  owner_t            last_owner,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              grant_if,
  output logic              grant_ls
);

  logic if_wins_tie;

  always_comb begin
    if_wins_tie = 1'b0;
    if (LSU_PRIO != 0) begin
      // LSU normally wins; a starved IFU is forced through once
      if_wins_tie = (wait_cnt == WAIT_W'(MAX_WAIT));
    end else begin
      if_wins_tie = (last_owner == OWN_LS);
    end
  end

  assign grant_if = if_valid & (~ls_valid | if_wins_tie);
  assign grant_ls = ls_valid & (~if_valid | ~if_wins_tie);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port,
// one transaction outstanding, IDLE -> REQ -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LSU_PRIO = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_write,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                arb_err
);

  localparam int MASK_W = mask_width(DATA_W);

  state_t              state_reg;
  owner_t              owner_reg;
  owner_t              last_owner_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                arb_err_reg;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [MASK_W-1:0]   wmask_reg;

  logic grant_if, grant_ls;
  logic in_idle, accept_if, accept_ls, take_resp, spurious;

  mem_arb_pick #(
    .LSU_PRIO(LSU_PRIO),
    .MAX_WAIT(MAX_WAIT)
  ) u_pick (
    .if_valid  (if_req_valid),
    .ls_valid  (ls_req_valid),
    .last_owner(last_owner_reg),
    .wait_cnt  (wait_cnt_reg),
    .grant_if  (grant_if),
    .grant_ls  (grant_ls)
  );

  // Combinational outputs are held low while reset is asserted
  assign in_idle   = rst_n && (state_reg == ST_IDLE);
  assign accept_if = in_idle && grant_if;
  assign accept_ls = in_idle && grant_ls;
  assign take_resp = rst_n && mem_resp_valid &&
                     ((state_reg == ST_RESP) || (state_reg == ST_REQ && mem_req_ready));
  assign spurious  = mem_resp_valid &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_REQ && !mem_req_ready));

  assign if_req_ready  = accept_if;
  assign ls_req_ready  = accept_ls;
  assign if_resp_valid = take_resp && (owner_reg == OWN_IF);
  assign ls_resp_valid = take_resp && (owner_reg == OWN_LS);
  assign if_resp_rdata = if_resp_valid ? mem_resp_rdata : '0;
  assign ls_resp_rdata = (ls_resp_valid && !write_reg) ? mem_resp_rdata : '0;

  assign mem_req_valid = rst_n && (state_reg == ST_REQ);
  assign mem_req_write = write_reg;
  assign mem_req_addr  = addr_reg;
  assign mem_req_wdata = wdata_reg;
  assign mem_req_wmask = wmask_reg;
  assign arb_err       = arb_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_IF;
      last_owner_reg <= OWN_IF;
      wait_cnt_reg   <= '0;
      arb_err_reg    <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_if || accept_ls) begin
            owner_reg      <= accept_ls ? OWN_LS : OWN_IF;
            last_owner_reg <= accept_ls ? OWN_LS : OWN_IF;
            addr_reg       <= accept_ls ? ls_req_addr : if_req_addr;
            write_reg      <= accept_ls && ls_req_write;
            wdata_reg      <= (accept_ls && ls_req_write) ? ls_req_wdata : '0;
            wmask_reg      <= (accept_ls && ls_req_write) ? ls_req_wmask : '0;
            state_reg      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_reg <= mem_resp_valid ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (spurious) begin
        arb_err_reg <= 1'b1;
      end

      // Counts lost ties for the IFU; only meaningful with fixed priority
      if (!if_req_valid || accept_if) begin
        wait_cnt_reg <= '0;
      end else if ((LSU_PRIO != 0) && accept_ls &&
                   (wait_cnt_reg < WAIT_W'(MAX_WAIT))) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, grant-order sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        ls_req_valid, ls_req_write;
  logic [63:0] ls_req_addr, ls_req_wdata;
  logic [7:0]  ls_req_wmask;
  logic        mem_req_ready, mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  logic        if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid;
  logic [63:0] if_resp_rdata, ls_resp_rdata;
  logic        mem_req_valid, mem_req_write, arb_err;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;

  logic        r_if_req_ready, r_if_resp_valid, r_ls_req_ready, r_ls_resp_valid;
  logic [63:0] r_if_resp_rdata, r_ls_resp_rdata;
  logic        r_mem_req_valid, r_mem_req_write, r_arb_err;
  logic [63:0] r_mem_req_addr, r_mem_req_wdata;
  logic [7:0]  r_mem_req_wmask;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_PRIO(1), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_write(ls_req_write),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .arb_err(arb_err)
  );

  // Round-robin instance; its state sequence matches dut since timing is owner-independent
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_PRIO(0), .MAX_WAIT(MAX_WAIT)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(r_if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(r_if_resp_valid), .if_resp_rdata(r_if_resp_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(r_ls_req_ready), .ls_req_write(ls_req_write),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_resp_valid(r_ls_resp_valid), .ls_resp_rdata(r_ls_resp_rdata),
    .mem_req_valid(r_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(r_mem_req_write),
    .mem_req_addr(r_mem_req_addr), .mem_req_wdata(r_mem_req_wdata), .mem_req_wmask(r_mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .arb_err(r_arb_err)
  );

  typedef struct {
    logic        if_v;
    logic [63:0] if_addr;
    logic        ls_v;
    logic        ls_w;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        mrdy;
    logic        mresp;
    logic [63:0] mrdata;
    logic        e_if_rdy;
    logic        e_ls_rdy;
    logic        e_mvalid;
    logic        e_mwrite;
    logic [63:0] e_maddr;
    logic [63:0] e_mwdata;
    logic [7:0]  e_mwmask;
    logic        e_if_resp;
    logic        e_ls_resp;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t tbl [13];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    ls_req_valid   = 1'b0;
    ls_req_write   = 1'b0;
    ls_req_addr    = '0;
    ls_req_wdata   = '0;
    ls_req_wmask   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    if_req_valid = 1'b1;
    settle();
    chk("reset_if_ready", if_req_ready, 0);
    chk("reset_mem_valid", mem_req_valid, 0);
    chk("reset_arb_err", arb_err, 0);
    chk("reset_resp", {if_resp_valid, ls_resp_valid}, 0);
    tick();
    rst_n = 1'b1;
    if_req_valid = 1'b0;
  endtask

  // Reference grant rule: 0 none, 1 IF, 2 LS
  function automatic int pick(input bit iv, input bit lv, input int wt, input int last, input bit prio);
    if (!iv && !lv) return 0;
    if (iv && !lv) return 1;
    if (lv && !iv) return 2;
    if (prio) return (wt == MAX_WAIT) ? 1 : 2;
    return (last == 2) ? 1 : 2;
  endfunction

  // Random-run model state
  bit          m_busy, m_sent, m_w;
  int          m_wait, m_last, m_last_rr, m_own, win, rwin, n_done;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  bit          done;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    tbl[0]  = '{1'b1, 64'h80000000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 64'h80000000, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b1, 64'h00100073,
                1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h00100073};
    tbl[3]  = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h80001000, 64'hDEADBEEF, 8'h0F, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    for (int i = 5; i <= 8; i++)
      tbl[i] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h1234, 64'h1111, 8'hFF, (i == 8), 1'b0, 64'h0,
                 1'b0, 1'b0, 1'b1, 1'b1, 64'h80001000, 64'hDEADBEEF, 8'h0F, 1'b0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 64'h80000040, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h5555,
                1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0};
    tbl[10] = '{1'b1, 64'h80000040, 1'b1, 1'b0, 64'h80002000, 64'h9999, 8'hFF, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b1, 64'hCAFEF00D,
                1'b0, 1'b0, 1'b1, 1'b0, 64'h80002000, 64'h0, 8'h00, 1'b0, 1'b1, 64'hCAFEF00D};
    tbl[12] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 64'h0};

    do_reset();

    // Single fetch, store with delayed ready, load with coincident response
    for (int i = 0; i < 13; i++) begin
      tick();
      if_req_valid   = tbl[i].if_v;
      if_req_addr    = tbl[i].if_addr;
      ls_req_valid   = tbl[i].ls_v;
      ls_req_write   = tbl[i].ls_w;
      ls_req_addr    = tbl[i].ls_addr;
      ls_req_wdata   = tbl[i].ls_wdata;
      ls_req_wmask   = tbl[i].ls_wmask;
      mem_req_ready  = tbl[i].mrdy;
      mem_resp_valid = tbl[i].mresp;
      mem_resp_rdata = tbl[i].mrdata;
      settle();
      $display("vec %0d: if_rdy=%0b ls_rdy=%0b mvalid=%0b if_resp=%0b ls_resp=%0b",
               i, if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid);
      chk($sformatf("vec%0d_if_ready", i), if_req_ready, tbl[i].e_if_rdy);
      chk($sformatf("vec%0d_ls_ready", i), ls_req_ready, tbl[i].e_ls_rdy);
      chk($sformatf("vec%0d_mem_valid", i), mem_req_valid, tbl[i].e_mvalid);
      if (tbl[i].e_mvalid) begin
        chk($sformatf("vec%0d_mem_write", i), mem_req_write, tbl[i].e_mwrite);
        chk($sformatf("vec%0d_mem_addr", i), mem_req_addr, tbl[i].e_maddr);
        chk($sformatf("vec%0d_mem_wdata", i), mem_req_wdata, tbl[i].e_mwdata);
        chk($sformatf("vec%0d_mem_wmask", i), mem_req_wmask, tbl[i].e_mwmask);
      end
      chk($sformatf("vec%0d_if_resp", i), if_resp_valid, tbl[i].e_if_resp);
      chk($sformatf("vec%0d_ls_resp", i), ls_resp_valid, tbl[i].e_ls_resp);
      chk($sformatf("vec%0d_if_rdata", i), if_resp_rdata, tbl[i].e_if_resp ? tbl[i].e_rdata : 64'h0);
      chk($sformatf("vec%0d_ls_rdata", i), ls_resp_rdata, tbl[i].e_ls_resp ? tbl[i].e_rdata : 64'h0);
      chk($sformatf("vec%0d_arb_err", i), arb_err, 0);
    end

    // Grant order with both requesting continuously: fixed vs round-robin
    do_reset();
    for (int n = 0; n < 10; n++) begin
      bit exp_ls, exp_rr_ls;
      exp_ls    = (n % 5) != 4;
      exp_rr_ls = (n % 2) == 0;
      tick();
      if_req_valid   = 1'b1;
      if_req_addr    = 64'h1000 + 64'(n);
      ls_req_valid   = 1'b1;
      ls_req_write   = 1'b0;
      ls_req_addr    = 64'h2000 + 64'(n);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      settle();
      $display("grant %0d: fixed=%s rr=%s", n, ls_req_ready ? "LS" : (if_req_ready ? "IF" : "--"),
               r_ls_req_ready ? "LS" : (r_if_req_ready ? "IF" : "--"));
      chk($sformatf("prio%0d_ls_ready", n), ls_req_ready, exp_ls);
      chk($sformatf("prio%0d_if_ready", n), if_req_ready, !exp_ls);
      chk($sformatf("rr%0d_ls_ready", n), r_ls_req_ready, exp_rr_ls);
      chk($sformatf("rr%0d_if_ready", n), r_if_req_ready, !exp_rr_ls);
      tick();
      mem_req_ready = 1'b1;
      settle();
      chk($sformatf("prio%0d_addr", n), mem_req_addr, exp_ls ? 64'h2000 + 64'(n) : 64'h1000 + 64'(n));
      chk($sformatf("rr%0d_addr", n), r_mem_req_addr, exp_rr_ls ? 64'h2000 + 64'(n) : 64'h1000 + 64'(n));
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'(n);
      settle();
      chk($sformatf("prio%0d_resp", n), {if_resp_valid, ls_resp_valid}, exp_ls ? 2'b01 : 2'b10);
      chk($sformatf("rr%0d_resp", n), {r_if_resp_valid, r_ls_resp_valid}, exp_rr_ls ? 2'b01 : 2'b10);
    end

    // Spurious response in IDLE
    tick();
    idle_inputs();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h77;
    settle();
    chk("spur_resp", {if_resp_valid, ls_resp_valid}, 0);
    chk("spur_err_before", arb_err, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_resp_valid = 1'b0;
      settle();
      $display("spurious hold %0d: arb_err=%0b", k, arb_err);
      chk($sformatf("spur_err_sticky%0d", k), arb_err, 1);
    end

    // Reset while in RESP, late response after release, then a normal fetch
    do_reset();
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h80000100;
    settle();
    chk("rst_if_ready", if_req_ready, 1);
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("rst_mem_valid", mem_req_valid, 1);
    tick();
    mem_req_ready = 1'b0;
    rst_n         = 1'b0;
    settle();
    chk("rst_in_resp_outputs", {if_resp_valid, ls_resp_valid, mem_req_valid, if_req_ready}, 0);
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBAD;
    settle();
    chk("rst_late_resp", {if_resp_valid, ls_resp_valid}, 0);
    chk("rst_late_rdata", if_resp_rdata, 0);
    tick();
    mem_resp_valid = 1'b0;
    if_req_valid   = 1'b1;
    if_req_addr    = 64'h80000200;
    settle();
    chk("rst_err_set", arb_err, 1);
    chk("rst_idle_accept", if_req_ready, 1);
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("rst_fetch_addr", mem_req_addr, 64'h80000200);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h13;
    settle();
    $display("post-reset fetch: if_resp=%0b rdata=%h", if_resp_valid, if_resp_rdata);
    chk("rst_fetch_resp", if_resp_valid, 1);
    chk("rst_fetch_rdata", if_resp_rdata, 64'h13);

    // Randomized run against the transaction-level model
    do_reset();
    m_busy = 0; m_sent = 0; m_wait = 0; m_last = 1; m_last_rr = 1; m_own = 0; n_done = 0;
    m_w = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if_req_valid   = 1'($urandom_range(0, 1));
      if_req_addr    = {$urandom, $urandom};
      ls_req_valid   = 1'($urandom_range(0, 1));
      ls_req_write   = 1'($urandom_range(0, 1));
      ls_req_addr    = {$urandom, $urandom};
      ls_req_wdata   = {$urandom, $urandom};
      ls_req_wmask   = 8'($urandom);
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_rdata = {$urandom, $urandom};
      if (m_busy && m_sent)       mem_resp_valid = 1'($urandom_range(0, 1));
      else if (m_busy && mem_req_ready) mem_resp_valid = ($urandom_range(0, 3) == 0);
      else                        mem_resp_valid = 1'b0;
      settle();

      win  = m_busy ? 0 : pick(if_req_valid, ls_req_valid, m_wait, m_last, 1'b1);
      rwin = m_busy ? 0 : pick(if_req_valid, ls_req_valid, 0, m_last_rr, 1'b0);
      chk("rnd_if_ready", if_req_ready, win == 1);
      chk("rnd_ls_ready", ls_req_ready, win == 2);
      chk("rnd_rr_if_ready", r_if_req_ready, rwin == 1);
      chk("rnd_rr_ls_ready", r_ls_req_ready, rwin == 2);
      chk("rnd_mem_valid", mem_req_valid, m_busy && !m_sent);
      if (m_busy && !m_sent) begin
        chk("rnd_mem_write", mem_req_write, m_w);
        chk("rnd_mem_addr", mem_req_addr, m_addr);
        chk("rnd_mem_wdata", mem_req_wdata, m_wdata);
        chk("rnd_mem_wmask", mem_req_wmask, m_wmask);
      end
      done = m_busy && mem_resp_valid;
      chk("rnd_if_resp", if_resp_valid, done && m_own == 1);
      chk("rnd_ls_resp", ls_resp_valid, done && m_own == 2);
      chk("rnd_if_rdata", if_resp_rdata, (done && m_own == 1) ? mem_resp_rdata : 64'h0);
      chk("rnd_ls_rdata", ls_resp_rdata, (done && m_own == 2 && !m_w) ? mem_resp_rdata : 64'h0);
      chk("rnd_arb_err", arb_err, 0);
      if (done) begin
        n_done++;
        $display("rnd txn %0d: owner=%s write=%0b addr=%h", n_done, (m_own == 1) ? "IF" : "LS", m_w, m_addr);
      end

      if (!if_req_valid) m_wait = 0;
      if (!m_busy && win != 0) begin
        m_busy  = 1;
        m_sent  = 0;
        m_own   = win;
        m_last  = win;
        m_last_rr = rwin;
        m_w     = (win == 2) && ls_req_write;
        m_addr  = (win == 2) ? ls_req_addr : if_req_addr;
        m_wdata = m_w ? ls_req_wdata : 64'h0;
        m_wmask = m_w ? ls_req_wmask : 8'h0;
        if (win == 1) m_wait = 0;
        else if (if_req_valid && m_wait < MAX_WAIT) m_wait++;
      end else if (m_busy && !m_sent && mem_req_ready) begin
        if (mem_resp_valid) m_busy = 0;
        else m_sent = 1;
      end else if (m_busy && m_sent && mem_resp_valid) begin
        m_busy = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single simulated physical-memory port (DPI pmem_read/pmem_write backend) between instruction fetch (IFU, read-only) and load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory wrapper.
- Serialises accesses with valid/ready request handshakes and a single-cycle response pulse, with at most one transaction outstanding.
- Replaces the two independent combinational read paths with one sequenced port.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; wmask width is DATA_W/8.
- LSU_PRIO, 1. 1 = fixed LSU priority with an anti-starvation counter; 0 = round-robin.
- MAX_WAIT, 4. Consecutive lost arbitrations after which the IFU is force-granted (LSU_PRIO=1 only); range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req_valid  in  1  IFU request
- if_req_ready  out  1  IFU request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address (pc)
- if_resp_valid  out  1  fetch data valid, one-cycle pulse
- if_resp_rdata  out  DATA_W  fetched data
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_req_write  in  1  1 = store, 0 = load
- ls_req_addr  in  ADDR_W  load/store address
- ls_req_wdata  in  DATA_W  store data
- ls_req_wmask  in  DATA_W/8  store byte mask
- ls_resp_valid  out  1  load data / store ack, one-cycle pulse
- ls_resp_rdata  out  DATA_W  load data; 0 for a store ack
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  write request
- mem_req_addr  out  ADDR_W  address
- mem_req_wdata  out  DATA_W  write data; 0 on reads
- mem_req_wmask  out  DATA_W/8  write mask; 0 on reads
- mem_resp_valid  in  1  memory response (reads and writes)
- mem_resp_rdata  in  DATA_W  read data
- arb_err  out  1  sticky error: spurious mem_resp_valid

Behaviour:
- Reset is synchronous and active-low on rst_n. It forces:
  - state to IDLE;
  - all outputs to 0 and all latched request registers to 0;
  - last_owner to IF;
  - wait_cnt to 0;
  - arb_err to 0.
- An outstanding transaction is dropped on reset. A mem_resp_valid arriving afterwards counts as spurious.
- States: IDLE, REQ, RESP. The owner register (IF/LS) is valid in REQ and RESP.
- IDLE:
  - Arbitrate among asserted *_req_valid. Assert the winner's *_req_ready combinationally in the same cycle.
  - Latch its addr/write/wdata/wmask and the owner. For IF, write=0 and wdata/wmask=0.
  - Go to REQ.
  - The loser's ready stays 0. Both readies are 0 outside IDLE.
- REQ:
  - mem_req_valid=1 with the latched payload, held stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
  - If mem_req_valid and mem_req_ready coincide with mem_resp_valid in the same cycle, the response is taken immediately. Assert the owner's resp_valid and go to IDLE.
- RESP:
  - mem_req_valid=0.
  - On mem_resp_valid, set owner's *_resp_valid=1 combinationally for that cycle.
  - rdata = mem_resp_rdata, except ls_resp_rdata = 0 for a store.
  - Go to IDLE.
- Minimum throughput: 1 accept + 1 request + 1 response cycle. A new accept occurs no earlier than the cycle after a response.
- Non-owner resp_valid is always 0. Non-owner resp_rdata is driven as 0.
- Arbitration, LSU_PRIO=1:
  - LSU wins ties, except the IFU wins if wait_cnt == MAX_WAIT.
  - wait_cnt increments on each IDLE cycle where both are valid and LSU wins.
  - wait_cnt clears when the IFU is granted or if_req_valid=0. It saturates at MAX_WAIT.
- Arbitration, LSU_PRIO=0:
  - On a tie, grant the requester that is not last_owner.
  - last_owner updates on every grant.
  - After reset, the first tie goes to LS.
- A single requester is granted immediately in both modes.
- arb_err sets when mem_resp_valid=1 in IDLE or REQ (except the coincident REQ case above). It clears only on reset. The spurious response is otherwise ignored.
- Requesters may drop *_req_valid at any time before acceptance without effect. After acceptance, input changes are ignored because the payload is latched.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/REQ/RESP);
  - the owner enum (OWN_IF/OWN_LS);
  - width localparams derived from ADDR_W/DATA_W.
- One sub-module, mem_arb_pick: purely combinational arbitration decision. Inputs are the two valids, last_owner, wait_cnt, LSU_PRIO and MAX_WAIT. Outputs are grant_if and grant_ls.
- The FSM, payload latches, wait_cnt and last_owner live in the top.

Test Plan:
- Single fetch: if_req_valid with addr 0x80000000, mem_req_ready tied 1, response rdata 0x00100073 one cycle after request.
  - if_req_ready in cycle 0, mem_req_valid in cycle 1.
  - if_resp_valid one cycle with 0x00100073; ls_resp_valid stays 0.
- Store:
  - Stimulus: ls write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready delayed 3 cycles.
  - Required: payload stable through all REQ cycles; ack yields ls_resp_valid with ls_resp_rdata 0.
- Fixed priority, MAX_WAIT=4: both requesting continuously.
  - Grant order LS, LS, LS, LS, IF, LS, ...
  - wait_cnt returns to 0 after the IF grant.
- Round-robin (LSU_PRIO=0): both requesting continuously after reset → grants alternate LS, IF, LS, IF.
- Spurious response: mem_resp_valid pulsed in IDLE → arb_err=1 and stays 1. No resp_valid to either port.
- Reset mid-operation: rst_n low in RESP, then mem_resp_valid after release → state IDLE, no resp_valid, arb_err=1. A subsequent IFU fetch completes normally.
